// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: 2-bit saturating PHT plus tagged BTB, with
// fetch-stage lookup, Execute-stage resolution/redirect and a post-reset table clear.
module branch_predict_ctrl #(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredPCF,
  output logic        BusyF,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredPCE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirectE,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount,
  output logic        state_dbg
);

  localparam int unsigned DEPTH    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [IDX_BITS-1:0] ptr, ptr_next;

  logic [1:0]          pht        [DEPTH];
  logic [DEPTH-1:0]    btb_valid;
  logic [TAG_BITS-1:0] btb_tag    [DEPTH];
  logic [31:0]         btb_target [DEPTH];

  logic                run;
  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic [31:0]         pc_plus4_f, pc_plus4_e;
  logic                hit_f;
  logic                upd_e;
  logic                mispredict_e;
  logic [1:0]          cnt_e, cnt_e_next;

  // ---------------------------------------------------------------------------
  // Init / run sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_INIT: begin
        ptr_next = ptr + {{(IDX_BITS-1){1'b0}}, 1'b1};
        if (&ptr) state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  assign run       = (state == ST_RUN);
  assign BusyF     = ~run;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Fetch-stage lookup (reads pre-update table contents, no bypass)
  // ---------------------------------------------------------------------------
  assign idx_f      = PCF[IDX_BITS+1:2];
  assign tag_f      = PCF[31:IDX_BITS+2];
  assign pc_plus4_f = PCF + 32'd4;
  assign hit_f      = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);

  always_comb begin
    PredTakenF = 1'b0;
    PredPCF    = pc_plus4_f;
    if (run && pht[idx_f][1] && hit_f) begin
      PredTakenF = 1'b1;
      PredPCF    = btb_target[idx_f];
    end
  end

  // ---------------------------------------------------------------------------
  // Execute-stage resolution
  // ---------------------------------------------------------------------------
  assign idx_e      = PCE[IDX_BITS+1:2];
  assign tag_e      = PCE[31:IDX_BITS+2];
  assign pc_plus4_e = PCE + 32'd4;
  assign upd_e      = run & BranchE;

  // A correctly-predicted taken branch still misses if it went to the wrong target.
  assign mispredict_e = upd_e &
                        ((TakenE != PredTakenE) |
                         (TakenE & PredTakenE & (PredPCE != PCTargetE)));

  always_comb begin
    FlushD     = mispredict_e;
    FlushE     = mispredict_e;
    RedirectE  = mispredict_e;
    RedirectPC = 32'd0;
    if (mispredict_e) RedirectPC = TakenE ? PCTargetE : pc_plus4_e;
  end

  assign cnt_e = pht[idx_e];

  always_comb begin
    cnt_e_next = cnt_e;
    if (TakenE) begin
      if (cnt_e != 2'b11) cnt_e_next = cnt_e + 2'b01;
    end else begin
      if (cnt_e != 2'b00) cnt_e_next = cnt_e - 2'b01;
    end
  end

  // ---------------------------------------------------------------------------
  // Table storage; contents are cleared by the INIT sweep rather than by reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) begin
        pht[ptr]       <= CNT_INIT;
        btb_valid[ptr] <= 1'b0;
      end else if (upd_e) begin
        pht[idx_e] <= cnt_e_next;
        if (TakenE) begin
          btb_valid[idx_e]  <= 1'b1;
          btb_tag[idx_e]    <= tag_e;
          btb_target[idx_e] <= PCTargetE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BranchCount <= 32'd0;
      MissCount   <= 32'd0;
    end else begin
      if (upd_e)        BranchCount <= BranchCount + 32'd1;
      if (mispredict_e) MissCount   <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: init sweep, training, recovery,
// aliasing, wrong-target, back-to-back updates and reset during RUN.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredPCF;
  logic        BusyF;
  logic        BranchE;
  logic        TakenE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic        PredTakenE;
  logic [31:0] PredPCE;
  logic        FlushD;
  logic        FlushE;
  logic        RedirectE;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;
  logic        state_dbg;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.IDX_BITS(6), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .BusyF(BusyF), .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE), .PCTargetE(PCTargetE),
    .PredTakenE(PredTakenE), .PredPCE(PredPCE), .FlushD(FlushD), .FlushE(FlushE),
    .RedirectE(RedirectE), .RedirectPC(RedirectPC), .BranchCount(BranchCount),
    .MissCount(MissCount), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge, outputs read 1ns later
  // ---------------------------------------------------------------------------
  task automatic drive_e(input logic br, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
    BranchE = br; TakenE = tk; PCE = pc; PCTargetE = tgt; PredTakenE = ptk; PredPCE = ppc;
  endtask

  task automatic idle_e();
    drive_e(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Counts falling edges with BusyF high, starting at the current one; capped at 200.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (BusyF !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int n;
    rst_n = 1'b0; PCF = 32'h0000_0100;
    drive_e(1'b1, 1'b1, 32'h100, 32'h40, 1'b0, 32'h104);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vec_count++; if (BusyF !== 1'b1) begin miss_count++; $display("FAIL reset_busy: got %0b want 1", BusyF); end
    vec_count++; if (state_dbg !== 1'b0) begin miss_count++; $display("FAIL reset_state: got %0b want 0", state_dbg); end
    vec_count++; if (BranchCount !== 32'd0 || MissCount !== 32'd0) begin miss_count++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", BranchCount, MissCount); end
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h104) begin miss_count++;
      $display("FAIL reset_pred: got %0b/%h want 0/00000104", PredTakenF, PredPCF); end
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b000 || RedirectPC !== 32'd0) begin miss_count++;
      $display("FAIL reset_flush: got %b/%h want 000/00000000", {FlushD, FlushE, RedirectE}, RedirectPC); end
    // Branch inputs stay active throughout INIT and must be ignored.
    rst_n = 1'b1;
    count_busy(n);
    vec_count++; if (n !== 64) begin miss_count++; $display("FAIL init_len: got %0d want 64", n); end
    idle_e();
    #1;
    vec_count++; if (BranchCount !== 32'd0 || MissCount !== 32'd0) begin miss_count++;
      $display("FAIL init_ignored: got %0d/%0d want 0/0", BranchCount, MissCount); end
    PCF = 32'h0000_0100; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h104) begin miss_count++;
      $display("FAIL init_clear_100: got %0b/%h want 0/00000104", PredTakenF, PredPCF); end
    PCF = 32'hFFFF_FFFC; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h0) begin miss_count++;
      $display("FAIL init_wrap: got %0b/%h want 0/00000000", PredTakenF, PredPCF); end
  endtask

  task automatic test_train();
    PCF = 32'h100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_e(1'b1, 1'b1, 32'h100, 32'h40, 1'b0, 32'h104); #1;
      vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b111 || RedirectPC !== 32'h40) begin miss_count++;
        $display("FAIL train_redirect%0d: got %b/%h want 111/00000040", k, {FlushD, FlushE, RedirectE}, RedirectPC); end
    end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (PredTakenF !== 1'b1 || PredPCF !== 32'h40) begin miss_count++;
      $display("FAIL train_pred: got %0b/%h want 1/00000040", PredTakenF, PredPCF); end
    vec_count++; if (BranchCount !== 32'd2 || MissCount !== 32'd2) begin miss_count++;
      $display("FAIL train_counts: got %0d/%0d want 2/2", BranchCount, MissCount); end
    // Correct taken prediction: no redirect, counter saturates at 11.
    drive_e(1'b1, 1'b1, 32'h100, 32'h40, 1'b1, 32'h40); #1;
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b000 || RedirectPC !== 32'd0) begin miss_count++;
      $display("FAIL hit_noflush: got %b/%h want 000/00000000", {FlushD, FlushE, RedirectE}, RedirectPC); end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (BranchCount !== 32'd3 || MissCount !== 32'd2) begin miss_count++;
      $display("FAIL hit_counts: got %0d/%0d want 3/2", BranchCount, MissCount); end
  endtask

  task automatic test_alias();
    PCF = 32'h200; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h204) begin miss_count++;
      $display("FAIL alias_tag: got %0b/%h want 0/00000204", PredTakenF, PredPCF); end
    PCF = 32'h104; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h108) begin miss_count++;
      $display("FAIL other_idx: got %0b/%h want 0/00000108", PredTakenF, PredPCF); end
  endtask

  task automatic test_not_taken();
    PCF = 32'h100;
    drive_e(1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40); #1;
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b111 || RedirectPC !== 32'h104) begin miss_count++;
      $display("FAIL nt1_redirect: got %b/%h want 111/00000104", {FlushD, FlushE, RedirectE}, RedirectPC); end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (PredTakenF !== 1'b1 || PredPCF !== 32'h40) begin miss_count++;
      $display("FAIL nt1_pred: got %0b/%h want 1/00000040", PredTakenF, PredPCF); end
    drive_e(1'b1, 1'b0, 32'h100, 32'h40, 1'b1, 32'h40); #1;
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b111 || RedirectPC !== 32'h104) begin miss_count++;
      $display("FAIL nt2_redirect: got %b/%h want 111/00000104", {FlushD, FlushE, RedirectE}, RedirectPC); end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h104) begin miss_count++;
      $display("FAIL nt2_pred: got %0b/%h want 0/00000104", PredTakenF, PredPCF); end
    vec_count++; if (BranchCount !== 32'd5 || MissCount !== 32'd4) begin miss_count++;
      $display("FAIL nt_counts: got %0d/%0d want 5/4", BranchCount, MissCount); end
  endtask

  task automatic test_wrong_target();
    PCF = 32'h100;
    drive_e(1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h40); #1;
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b111 || RedirectPC !== 32'h80) begin miss_count++;
      $display("FAIL wt_redirect: got %b/%h want 111/00000080", {FlushD, FlushE, RedirectE}, RedirectPC); end
    vec_count++; if (PredTakenF !== 1'b0) begin miss_count++;
      $display("FAIL wt_no_bypass: got %0b want 0", PredTakenF); end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (PredTakenF !== 1'b1 || PredPCF !== 32'h80) begin miss_count++;
      $display("FAIL wt_pred: got %0b/%h want 1/00000080", PredTakenF, PredPCF); end
  endtask

  task automatic test_no_branch();
    drive_e(1'b0, 1'b1, 32'h100, 32'h999, 1'b0, 32'h0); #1;
    vec_count++; if ({FlushD, FlushE, RedirectE} !== 3'b000 || RedirectPC !== 32'd0) begin miss_count++;
      $display("FAIL nobr_flush: got %b/%h want 000/00000000", {FlushD, FlushE, RedirectE}, RedirectPC); end
    @(negedge clk); idle_e(); #1;
    vec_count++; if (BranchCount !== 32'd6 || MissCount !== 32'd5) begin miss_count++;
      $display("FAIL nobr_counts: got %0d/%0d want 6/5", BranchCount, MissCount); end
    PCF = 32'h100; #1;
    vec_count++; if (PredPCF !== 32'h80) begin miss_count++;
      $display("FAIL nobr_btb: got %h want 00000080", PredPCF); end
  endtask

  task automatic test_back_to_back();
    drive_e(1'b1, 1'b1, 32'h10, 32'h1000, 1'b0, 32'h14); #1;
    vec_count++; if (RedirectE !== 1'b1 || RedirectPC !== 32'h1000) begin miss_count++;
      $display("FAIL b2b_first: got %0b/%h want 1/00001000", RedirectE, RedirectPC); end
    @(negedge clk);
    drive_e(1'b1, 1'b0, 32'h14, 32'h2000, 1'b0, 32'h18); #1;
    vec_count++; if (RedirectE !== 1'b0 || RedirectPC !== 32'd0) begin miss_count++;
      $display("FAIL b2b_second: got %0b/%h want 0/00000000", RedirectE, RedirectPC); end
    @(negedge clk); idle_e();
    PCF = 32'h10; #1;
    vec_count++; if (PredTakenF !== 1'b1 || PredPCF !== 32'h1000) begin miss_count++;
      $display("FAIL b2b_pred10: got %0b/%h want 1/00001000", PredTakenF, PredPCF); end
    PCF = 32'h14; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h18) begin miss_count++;
      $display("FAIL b2b_pred14: got %0b/%h want 0/00000018", PredTakenF, PredPCF); end
    vec_count++; if (BranchCount !== 32'd8 || MissCount !== 32'd6) begin miss_count++;
      $display("FAIL b2b_counts: got %0d/%0d want 8/6", BranchCount, MissCount); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    vec_count++; if (BranchCount !== 32'd0 || MissCount !== 32'd0) begin miss_count++;
      $display("FAIL rrun_counts: got %0d/%0d want 0/0", BranchCount, MissCount); end
    count_busy(n);
    vec_count++; if (n !== 64) begin miss_count++; $display("FAIL rrun_init_len: got %0d want 64", n); end
    PCF = 32'h100; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h104) begin miss_count++;
      $display("FAIL rrun_clear100: got %0b/%h want 0/00000104", PredTakenF, PredPCF); end
    PCF = 32'h10; #1;
    vec_count++; if (PredTakenF !== 1'b0 || PredPCF !== 32'h14) begin miss_count++;
      $display("FAIL rrun_clear10: got %0b/%h want 0/00000014", PredTakenF, PredPCF); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_not_taken();
    test_wrong_target();
    test_no_branch();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch prediction controller for the 5-stage RV32I pipeline. Owns a 2-bit saturating pattern history table (PHT) and a tagged branch target buffer (BTB).
- Produces fetch-stage predictions and resolves them in Execute.
- On a misprediction it sequences the D/E flush and the PC redirect.
- An init FSM clears both tables after reset while stalling fetch.

Parameters:
IDX_BITS, 6, table index width; DEPTH = 2^IDX_BITS entries (64).
CNT_INIT, 2'b01, PHT value written during init (weakly not-taken).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
PCF  in  32  fetch-stage PC used for lookup
PredTakenF  out  1  fetch predicts taken
PredPCF  out  32  predicted next PC (BTB target if PredTakenF, else PCF+4)
BusyF  out  1  init in progress; fetch must stall
BranchE  in  1  valid conditional branch in Execute this cycle
TakenE  in  1  resolved outcome of the branch in Execute
PCE  in  32  PC of the branch in Execute
PCTargetE  in  32  resolved branch target
PredTakenE  in  1  PredTakenF carried down the pipeline with this branch
PredPCE  in  32  PredPCF carried down the pipeline with this branch
FlushD  out  1  flush Decode register
FlushE  out  1  flush Execute register
RedirectE  out  1  PC mux select for correction
RedirectPC  out  32  corrected PC
BranchCount  out  32  resolved branches since reset
MissCount  out  32  mispredictions since reset

Behaviour:
- Addressing
  - Index = PC[IDX_BITS+1:2]; tag = PC[31:IDX_BITS+2].
  - PHT is untagged. BTB entry = {valid, tag, target}.
- FSM states: INIT, RUN.
  - Reset (rst_n=0 at a clock edge) forces INIT with ptr=0. This applies at any time, including mid-INIT or mid-RUN.
  - INIT: each cycle writes PHT[ptr]=CNT_INIT and BTB valid[ptr]=0, then ptr++.
  - INIT lasts exactly DEPTH cycles; INIT→RUN after ptr=DEPTH-1 is written.
  - During INIT: BusyF=1, PredTakenF=0, PredPCF=PCF+4, updates ignored, FlushD/FlushE/RedirectE=0.
- Prediction (RUN, combinational from PCF)
  - PredTakenF = PHT[idx][1] & valid[idx] & (tag[idx]==PCF tag).
  - PredPCF = PredTakenF ? target[idx] : PCF+4 (32-bit wrap).
- Resolution (RUN, combinational from E-stage inputs, active only when BranchE=1)
  - Mispredict = (TakenE != PredTakenE) | (TakenE & PredTakenE & PredPCE != PCTargetE).
  - On mispredict: FlushD=FlushE=RedirectE=1 in the same cycle.
  - RedirectPC = TakenE ? PCTargetE : PCE+4.
  - Otherwise all three are 0 and RedirectPC=0.
- Update (RUN, registered at the edge of the cycle where BranchE=1)
  - PHT[idxE] saturates: increments toward 2'b11 if TakenE, decrements toward 2'b00 if not.
  - If TakenE: BTB[idxE] is written with valid=1, tagE, PCTargetE.
  - If not taken: the BTB is unchanged.
  - BranchCount increments; MissCount increments on mispredict. Both wrap at 2^32.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update (old) value. There is no bypass.
- Reset values
  - BusyF=1 (state INIT).
  - BranchCount=MissCount=0.
  - All combinational outputs take their INIT values listed above.
- BranchE=0: no table or counter change, no flush, whatever TakenE is.

Test Plan:
- Init: release rst_n → BusyF=1 for exactly 64 cycles, then 0. Any PCF then gives PredTakenF=0, PredPCF=PCF+4.
- Train: branch PCE=0x100, target 0x40, TakenE=1 twice with PredTakenE=0.
  - Both cycles: FlushD=FlushE=RedirectE=1, RedirectPC=0x40.
  - Afterwards PCF=0x100 gives PredTakenF=1, PredPCF=0x40; MissCount=2.
- Not-taken recovery: with PHT=11 at 0x100, send TakenE=0, PredTakenE=1.
  - Result: RedirectPC=0x104, flushes asserted, PHT→10, prediction still taken.
  - A second not-taken moves PHT→01 and the prediction becomes not-taken.
- Alias/tag: trained at 0x100, then PCF=0x200 (same index, different tag) → PredTakenF=0.
- Wrong target: PredTakenE=1, PredPCE=0x40, TakenE=1, PCTargetE=0x80 → mispredict, RedirectPC=0x80, BTB target updated to 0x80.
- Reset mid-RUN: after training, pulse rst_n low for one cycle.
  - Result: counters = 0, BusyF=1 for 64 cycles, and all predictions cleared afterwards.
